ad9361_spi_arbiter: RTL and testbench



---
 rtl/ad9361_spi_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_ad9361_spi_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9361_spi_arbiter.sv
// Two-requester round-robin arbiter and 24-bit single-byte SPI frame engine
// for the AD9361 4-wire control port, with read-data capture.
module ad9361_spi_arbiter #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic       sys_clk,
    input  logic       sys_nrst,
    input  logic       req0_valid,
    input  logic       req0_wr,
    input  logic [9:0] req0_addr,
    input  logic [7:0] req0_wdata,
    output logic       req0_ready,
    output logic       req0_done,
    output logic [7:0] req0_rdata,
    input  logic       req1_valid,
    input  logic       req1_wr,
    input  logic [9:0] req1_addr,
    input  logic [7:0] req1_wdata,
    output logic       req1_ready,
    output logic       req1_done,
    output logic [7:0] req1_rdata,
    output logic       spi_cs,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       busy,
    output logic       grant
);

    localparam int unsigned FRAME_W = 24;
    localparam int unsigned BIT_W   = 5;
    localparam int unsigned CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE,
        GAP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [FRAME_W-1:0]   frame;
    logic                 is_wr;
    logic [7:0]           rx;
    logic                 rr_last;

    logic                 accept_c;
    logic                 sel_wr_c;
    logic [9:0]           sel_addr_c;
    logic [7:0]           sel_wdata_c;
    logic [FRAME_W-1:0]   frame_c;

    // Round-robin arbitration: on contention the requester not granted last wins.
    assign req0_ready = sys_nrst && (state == IDLE) && req0_valid && (!req1_valid || rr_last);
    assign req1_ready = sys_nrst && (state == IDLE) && req1_valid && (!req0_valid || !rr_last);
    assign accept_c   = req0_ready || req1_ready;

    // Mux the winning request into the outgoing frame word.
    always_comb begin
        sel_wr_c    = req0_wr;
        sel_addr_c  = req0_addr;
        sel_wdata_c = req0_wdata;
        if (req1_ready) begin
            sel_wr_c    = req1_wr;
            sel_addr_c  = req1_addr;
            sel_wdata_c = req1_wdata;
        end
        frame_c = {sel_wr_c, 3'b000, 2'b00, sel_addr_c, (sel_wr_c ? sel_wdata_c : 8'h00)};
    end

    // Frame sequencer: arbitration, SCLK generation, MOSI shift, MISO capture, done/rdata.
    always_ff @(posedge sys_clk) begin
        if (!sys_nrst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            frame      <= '0;
            is_wr      <= 1'b0;
            rx         <= '0;
            rr_last    <= 1'b1;
            grant      <= 1'b0;
            busy       <= 1'b0;
            spi_cs     <= 1'b1;
            spi_sclk   <= 1'b0;
            spi_mosi   <= 1'b0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            req0_rdata <= '0;
            req1_rdata <= '0;
        end else begin
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        grant    <= req1_ready;
                        rr_last  <= req1_ready;
                        frame    <= frame_c;
                        is_wr    <= sel_wr_c;
                        spi_mosi <= frame_c[FRAME_W-1];
                        spi_cs   <= 1'b0;
                        spi_sclk <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == DIV_LAST) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SHIFT: begin
                    // MISO is sampled at the end of the first SCLK-high cycle.
                    if (spi_sclk && (cnt == '0)) begin
                        rx <= {rx[6:0], spi_miso};
                    end
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (!spi_sclk) begin
                            spi_sclk <= 1'b1;
                        end else begin
                            spi_sclk <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                state <= HOLD;
                            end else begin
                                bit_cnt  <= bit_cnt + BIT_W'(1);
                                frame    <= {frame[FRAME_W-2:0], frame[FRAME_W-1]};
                                spi_mosi <= frame[FRAME_W-2];
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt == DIV_LAST) begin
                        cnt      <= '0;
                        spi_cs   <= 1'b1;
                        spi_mosi <= 1'b0;
                        state    <= DONE;
                        if (grant) begin
                            req1_done  <= 1'b1;
                            req1_rdata <= is_wr ? 8'h00 : rx;
                        end else begin
                            req0_done  <= 1'b1;
                            req0_rdata <= is_wr ? 8'h00 : rx;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    cnt   <= '0;
                    state <= GAP;
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ad9361_spi_arbiter.sv
// Directed bench for ad9361_spi_arbiter: default-timing instance plus a
// CLK_DIV=1 / GAP_CYCLES=1 instance, with an SPI slave model on each.
module tb_ad9361_spi_arbiter;

    logic       sys_clk = 1'b0;
    logic       sys_nrst;

    logic       req0_valid, req0_wr, req1_valid, req1_wr;
    logic [9:0] req0_addr, req1_addr;
    logic [7:0] req0_wdata, req1_wdata;
    logic       req0_ready, req0_done, req1_ready, req1_done;
    logic [7:0] req0_rdata, req1_rdata;
    logic       spi_cs, spi_sclk, spi_mosi, spi_miso, busy, grant;

    logic       f_req0_valid, f_req0_wr, f_req1_valid, f_req1_wr;
    logic [9:0] f_req0_addr, f_req1_addr;
    logic [7:0] f_req0_wdata, f_req1_wdata;
    logic       f_req0_ready, f_req0_done, f_req1_ready, f_req1_done;
    logic [7:0] f_req0_rdata, f_req1_rdata;
    logic       f_spi_cs, f_spi_sclk, f_spi_mosi, f_spi_miso, f_busy, f_grant;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    ad9361_spi_arbiter dut (
        .sys_clk(sys_clk), .sys_nrst(sys_nrst),
        .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .req0_done(req0_done), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .req1_done(req1_done), .req1_rdata(req1_rdata),
        .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .busy(busy), .grant(grant)
    );

    ad9361_spi_arbiter #(.CLK_DIV(1), .GAP_CYCLES(1)) dut_fast (
        .sys_clk(sys_clk), .sys_nrst(sys_nrst),
        .req0_valid(f_req0_valid), .req0_wr(f_req0_wr), .req0_addr(f_req0_addr), .req0_wdata(f_req0_wdata),
        .req0_ready(f_req0_ready), .req0_done(f_req0_done), .req0_rdata(f_req0_rdata),
        .req1_valid(f_req1_valid), .req1_wr(f_req1_wr), .req1_addr(f_req1_addr), .req1_wdata(f_req1_wdata),
        .req1_ready(f_req1_ready), .req1_done(f_req1_done), .req1_rdata(f_req1_rdata),
        .spi_cs(f_spi_cs), .spi_sclk(f_spi_sclk), .spi_mosi(f_spi_mosi), .spi_miso(f_spi_miso),
        .busy(f_busy), .grant(f_grant)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    logic [3:0] rdy_all, dn_all;
    logic [1:0] cs_v, sclk_v, mosi_v;
    assign rdy_all = {f_req1_ready, f_req0_ready, req1_ready, req0_ready};
    assign dn_all  = {f_req1_done, f_req0_done, req1_done, req0_done};
    assign cs_v    = {f_spi_cs, spi_cs};
    assign sclk_v  = {f_spi_sclk, spi_sclk};
    assign mosi_v  = {f_spi_mosi, spi_mosi};

    // Pin monitor / slave model state, per instance (0 = default, 1 = fast).
    logic [1:0]  cs_prev   = 2'b11;
    logic [1:0]  sclk_prev = 2'b00;
    int          rises[2];
    int          falls[2];
    int          cs_low[2];
    logic [23:0] mosi_sr[2];
    logic [7:0]  resp[2];
    int          done_cnt0 = 0;
    int          done_cnt1 = 0;

    // Slave drives read byte during SCLK periods 16..23, updated after each falling edge.
    assign spi_miso   = (falls[0] >= 16 && falls[0] < 24) ? resp[0][3'(23 - falls[0])] : 1'b0;
    assign f_spi_miso = (falls[1] >= 16 && falls[1] < 24) ? resp[1][3'(23 - falls[1])] : 1'b0;

    // Count CS-low cycles and SCLK edges, capture MOSI on each rising edge.
    always @(negedge sys_clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!cs_v[i] && cs_prev[i]) begin
                rises[i]   <= 0;
                falls[i]   <= 0;
                cs_low[i]  <= 1;
                mosi_sr[i] <= '0;
            end else if (!cs_v[i]) begin
                cs_low[i] <= cs_low[i] + 1;
                if (sclk_v[i] && !sclk_prev[i]) begin
                    rises[i]   <= rises[i] + 1;
                    mosi_sr[i] <= {mosi_sr[i][22:0], mosi_v[i]};
                end
                if (!sclk_v[i] && sclk_prev[i]) falls[i] <= falls[i] + 1;
            end
            cs_prev[i]   <= cs_v[i];
            sclk_prev[i] <= sclk_v[i];
        end
        done_cnt0 <= done_cnt0 + int'(req0_done);
        done_cnt1 <= done_cnt1 + int'(req1_done);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int idx, input logic v, input logic wr, input logic [9:0] addr,
                         input logic [7:0] wdata);
        if (idx == 0) begin
            req0_valid = v; req0_wr = wr; req0_addr = addr; req0_wdata = wdata;
        end else begin
            req1_valid = v; req1_wr = wr; req1_addr = addr; req1_wdata = wdata;
        end
    endtask

    task automatic wait_ready(input int k, input string tag, output int t);
        t = -1;
        for (int i = 0; i < 600; i++) begin
            #1;
            if (rdy_all[k]) begin
                t = cyc;
                break;
            end
            @(negedge sys_clk);
        end
        if (t < 0) check({tag, " ready timeout"}, 32'(0), 32'(1));
    endtask

    task automatic wait_done(input int k, input string tag, output int d);
        d = -1;
        for (int i = 0; i < 600; i++) begin
            #1;
            if (dn_all[k]) begin
                d = cyc;
                break;
            end
            @(negedge sys_clk);
        end
        if (d < 0) check({tag, " done timeout"}, 32'(0), 32'(1));
    endtask

    // One complete access on the default instance, checked end to end.
    task automatic access(input int idx, input logic wr, input logic [9:0] addr, input logic [7:0] wdata,
                          input logic [7:0] rsp, input logic [23:0] exp_frame, input logic [7:0] exp_rd,
                          input string tag);
        int t, d, other;
        resp[0] = rsp;
        drive(idx, 1'b1, wr, addr, wdata);
        wait_ready(idx, tag, t);
        @(negedge sys_clk);
        drive(idx, 1'b0, wr, addr, wdata);
        check({tag, " grant"}, 32'(grant), 32'(idx));
        check({tag, " busy/cs"}, 32'({busy, spi_cs}), 32'(2'b10));
        other = (idx == 0) ? done_cnt1 : done_cnt0;
        wait_done(idx, tag, d);
        check({tag, " latency"}, d - t, 201);
        check({tag, " mosi"}, 32'(mosi_sr[0]), 32'(exp_frame));
        check({tag, " rises"}, rises[0], 24);
        check({tag, " cs_low"}, cs_low[0], 200);
        check({tag, " rdata"}, 32'((idx == 0) ? req0_rdata : req1_rdata), 32'(exp_rd));
        check({tag, " other_done"}, (idx == 0) ? done_cnt1 : done_cnt0, other);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, d0, d1, dc;
        int tk[3];
        int dk[3];

        sys_nrst = 1'b0;
        drive(0, 1'b1, 1'b1, 10'h000, 8'h00);
        drive(1, 1'b0, 1'b0, 10'h000, 8'h00);
        f_req0_valid = 1'b0; f_req0_wr = 1'b0; f_req0_addr = '0; f_req0_wdata = '0;
        f_req1_valid = 1'b0; f_req1_wr = 1'b0; f_req1_addr = '0; f_req1_wdata = '0;
        resp[0] = 8'h00;
        resp[1] = 8'h00;
        repeat (3) @(negedge sys_clk);

        // Reset state, with a request already pending
        check("rst pins", 32'({spi_cs, spi_sclk, spi_mosi}), 32'(3'b100));
        check("rst busy/grant", 32'({busy, grant}), 32'(2'b00));
        check("rst ready", 32'({req1_ready, req0_ready}), 32'(2'b00));
        check("rst done", 32'({req1_done, req0_done}), 32'(2'b00));
        check("rst rdata", 32'({req1_rdata, req0_rdata}), 32'(0));
        drive(0, 1'b0, 1'b0, 10'h000, 8'h00);
        sys_nrst = 1'b1;
        @(negedge sys_clk);

        // Write 0x37A <- 0xA5 by req0, then read 0x037 by req1 returning 0x5C
        access(0, 1'b1, 10'h37A, 8'hA5, 8'hFF, 24'h837AA5, 8'h00, "wr0");
        access(1, 1'b0, 10'h037, 8'h99, 8'h5C, 24'h003700, 8'h5C, "rd1");

        // Contention straight after reset: req0 first, req1 GAP+1 after done, then req0 again
        sys_nrst = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_nrst = 1'b1;
        check("rst2 rdata1", 32'(req1_rdata), 32'(0));
        drive(0, 1'b1, 1'b1, 10'h100, 8'h11);
        drive(1, 1'b1, 1'b1, 10'h200, 8'h22);
        wait_ready(0, "arb a", t0);
        check("arb a loser", 32'(req1_ready), 32'(0));
        @(negedge sys_clk);
        drive(0, 1'b0, 1'b1, 10'h100, 8'h11);
        wait_done(0, "arb a", d0);
        wait_ready(1, "arb b", t1);
        check("arb b accept", t1 - d0, 5);
        @(negedge sys_clk);
        check("arb b grant", 32'(grant), 32'(1));
        drive(1, 1'b0, 1'b1, 10'h200, 8'h22);
        wait_done(1, "arb b", d1);
        check("arb b mosi", 32'(mosi_sr[0]), 32'(24'h820022));
        drive(0, 1'b1, 1'b1, 10'h100, 8'h11);
        drive(1, 1'b1, 1'b1, 10'h200, 8'h22);
        wait_ready(0, "arb c", t0);
        check("arb c loser", 32'(req1_ready), 32'(0));
        @(negedge sys_clk);
        drive(0, 1'b0, 1'b1, 10'h100, 8'h11);
        wait_done(0, "arb c", d0);
        wait_ready(1, "arb d", t1);
        @(negedge sys_clk);
        drive(1, 1'b0, 1'b1, 10'h200, 8'h22);
        wait_done(1, "arb d", d1);

        // req1 held valid across three back-to-back writes
        drive(1, 1'b1, 1'b1, 10'h155, 8'h3C);
        for (int k = 0; k < 3; k++) begin
            wait_ready(1, "burst", tk[k]);
            if (k == 2) begin
                @(negedge sys_clk);
                drive(1, 1'b0, 1'b1, 10'h155, 8'h3C);
            end
            wait_done(1, "burst", dk[k]);
            check("burst rises", rises[0], 24);
            check("burst mosi", 32'(mosi_sr[0]), 32'(24'h81553C));
            if (k > 0) check("burst gap", tk[k] - dk[k-1], 5);
        end

        // Reset in the middle of a frame; request stays valid and is replayed
        dc = done_cnt0;
        drive(0, 1'b1, 1'b1, 10'h0F0, 8'h81);
        wait_ready(0, "abort", t0);
        while (cyc < t0 + 60) @(negedge sys_clk);
        sys_nrst = 1'b0;
        @(negedge sys_clk);
        #1;
        check("abort pins", 32'({spi_cs, spi_sclk, busy}), 32'(3'b100));
        check("abort done", 32'(req0_done), 32'(0));
        sys_nrst = 1'b1;
        wait_ready(0, "abort re", t1);
        check("abort rearb", t1 - t0, 61);
        @(negedge sys_clk);
        drive(0, 1'b0, 1'b1, 10'h0F0, 8'h81);
        wait_done(0, "abort re", d0);
        check("abort latency", d0 - t1, 201);
        check("abort mosi", 32'(mosi_sr[0]), 32'(24'h80F081));
        check("abort rises", rises[0], 24);
        check("abort done_cnt", done_cnt0 - dc, 1);

        // CLK_DIV=1 / GAP_CYCLES=1 instance: read 0x2A5 returning 0xC3
        resp[1] = 8'hC3;
        f_req0_valid = 1'b1; f_req0_wr = 1'b0; f_req0_addr = 10'h2A5; f_req0_wdata = 8'h77;
        wait_ready(2, "fast", t0);
        @(negedge sys_clk);
        f_req0_valid = 1'b0;
        wait_done(2, "fast", d0);
        check("fast latency", d0 - t0, 51);
        check("fast mosi", 32'(mosi_sr[1]), 32'(24'h02A500));
        check("fast rises", rises[1], 24);
        check("fast cs_low", cs_low[1], 50);
        check("fast rdata", 32'(f_req0_rdata), 32'(8'hC3));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
